// File: rtl/emit_heartbeat.sv
// Periodic heartbeat frame emitter: 8-byte frames separated by PERIOD idle cycles.
// Optional macro HEARTBEAT_CRC8_EN replaces the XOR check byte with CRC-8 (poly 0x07).
module emit_heartbeat #(
    parameter int unsigned PERIOD  = 1000,
    parameter logic [7:0]  NODE_ID = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  status,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [23:0] GAP_LAST  = 24'(PERIOD - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t      state_q;
    logic [2:0]  byte_idx_q;
    logic [23:0] gap_cnt_q;
    logic        stop_pend_q;
    logic [7:0]  status_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        done_q;
    logic [31:0] result_q;

    logic [2:0]  idx_d;
    logic [7:0]  check_d;
    logic [7:0]  byte_d;

    // result_q is stable for the whole frame, so it serves directly as seq.
    logic [7:0] payload [6];
    assign payload[0] = NODE_ID;
    assign payload[1] = result_q[31:24];
    assign payload[2] = result_q[23:16];
    assign payload[3] = result_q[15:8];
    assign payload[4] = result_q[7:0];
    assign payload[5] = status_q;

`ifdef HEARTBEAT_CRC8_EN
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    always_comb begin
        check_d = 8'h00;
        for (int i = 0; i < 6; i++) begin
            check_d = crc8_step(check_d, payload[i]);
        end
    end
`else
    always_comb begin
        check_d = 8'h00;
        for (int i = 0; i < 6; i++) begin
            check_d = check_d ^ payload[i];
        end
    end
`endif

    assign idx_d = byte_idx_q + 3'd1;

    always_comb begin
        case (idx_d)
            3'd1:    byte_d = payload[0];
            3'd2:    byte_d = payload[1];
            3'd3:    byte_d = payload[2];
            3'd4:    byte_d = payload[3];
            3'd5:    byte_d = payload[4];
            3'd6:    byte_d = payload[5];
            3'd7:    byte_d = check_d;
            default: byte_d = SYNC_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            byte_idx_q  <= 3'd0;
            gap_cnt_q   <= 24'd0;
            stop_pend_q <= 1'b0;
            status_q    <= 8'h00;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= 32'd0;
        end else begin
            done_q   <= 1'b0;
            result_q <= result_q;
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_q     <= SEND;
                        byte_idx_q  <= 3'd0;
                        tx_data_q   <= SYNC_BYTE;
                        tx_valid_q  <= 1'b1;
                        status_q    <= status;
                        stop_pend_q <= 1'b0;
                    end
                end
                SEND: begin
                    if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (tx_ready) begin
                        if (byte_idx_q == 3'd7) begin
                            result_q   <= result_q + 32'd1;
                            done_q     <= 1'b1;
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= 8'h00;
                            byte_idx_q <= 3'd0;
                            gap_cnt_q  <= 24'd0;
                            // A stop arriving with the last byte still ends emission.
                            if (stop_pend_q || stop) begin
                                state_q     <= IDLE;
                                stop_pend_q <= 1'b0;
                            end else begin
                                state_q <= GAP;
                            end
                        end else begin
                            byte_idx_q <= idx_d;
                            tx_data_q  <= byte_d;
                        end
                    end
                end
                GAP: begin
                    if (stop) begin
                        state_q   <= IDLE;
                        gap_cnt_q <= 24'd0;
                    end else if (gap_cnt_q == GAP_LAST) begin
                        state_q    <= SEND;
                        gap_cnt_q  <= 24'd0;
                        byte_idx_q <= 3'd0;
                        tx_data_q  <= SYNC_BYTE;
                        tx_valid_q <= 1'b1;
                        status_q   <= status;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 24'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign done     = done_q;
    assign result   = result_q;

endmodule
